// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared sizes, requester ids and helpers for the write-back arbiter
package cdb_arbiter_pkg;
  localparam int ROB_SIZE_BIT = 5;
  localparam int CDB_NREQ = 4;
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 == n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and common-data-bus broadcast signals
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = CDB_NREQ,
  parameter int IDX_W = ROB_SIZE_BIT,
  parameter int DATA_W = 32,
  parameter int SRC_W = $clog2(N_REQ)
);
  logic rdy_in;
  logic clear;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ*IDX_W-1:0] req_rob_idx;
  logic [N_REQ*DATA_W-1:0] req_value;
  logic [N_REQ-1:0] req_ready;
  logic cdb_valid;
  logic [IDX_W-1:0] cdb_rob_idx;
  logic [DATA_W-1:0] cdb_value;
  logic [SRC_W-1:0] cdb_src;
  modport master (
    output rdy_in, clear, req_valid, req_rob_idx, req_value,
    input req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
  );
  modport slave (
    input rdy_in, clear, req_valid, req_rob_idx, req_value,
    output req_ready, cdb_valid, cdb_rob_idx, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input logic [N-1:0] req,
  input logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic any
);
  // scan ptr, ptr+1, ... modulo N and take the first set request
  always_comb begin
    logic [W-1:0] j;
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the ROB write-back bus among requesters with 1-entry holding slots
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = CDB_NREQ,
  parameter int IDX_W = ROB_SIZE_BIT,
  parameter int DATA_W = 32,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input logic clk_in,
  input logic rst_in,
  cdb_arbiter_if.slave bus
);
  logic [N_REQ-1:0] hold_valid;
  logic [IDX_W-1:0] hold_idx [N_REQ];
  logic [DATA_W-1:0] hold_value [N_REQ];
  logic [SRC_W-1:0] rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] gnt_idx;
  logic gnt_any;
  logic [N_REQ-1:0] ready;
  rr_arbiter #(.N(N_REQ), .W(SRC_W)) u_rr (
    .req(hold_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gnt_idx),
    .any(gnt_any)
  );
  // a slot accepts when empty or being drained this edge; depends only on state, never on req_valid
  assign ready = (bus.rdy_in && !bus.clear) ? (~hold_valid | grant) : '0;
  assign bus.req_ready = ready;
  // broadcast register, round-robin pointer and holding slots; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_valid <= '0;
      hold_idx <= '{default: '0};
      hold_value <= '{default: '0};
      rr_ptr <= '0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_rob_idx <= '0;
      bus.cdb_value <= '0;
      bus.cdb_src <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear) begin
        hold_valid <= '0;
        bus.cdb_valid <= 1'b0;
      end else begin
        bus.cdb_valid <= gnt_any;
        if (gnt_any) begin
          bus.cdb_rob_idx <= hold_idx[gnt_idx];
          bus.cdb_value <= hold_value[gnt_idx];
          bus.cdb_src <= gnt_idx;
          rr_ptr <= SRC_W'(wrap_inc(int'(gnt_idx), N_REQ));
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (bus.req_valid[i] && ready[i]) begin
            hold_valid[i] <= 1'b1;
            hold_idx[i] <= bus.req_rob_idx[i*IDX_W +: IDX_W];
            hold_value[i] <= bus.req_value[i*DATA_W +: DATA_W];
          end else if (grant[i]) begin
            hold_valid[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a slot-level model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  localparam int N = CDB_NREQ;
  localparam int IW = ROB_SIZE_BIT;
  localparam int DW = 32;
  localparam int SW = $clog2(N);
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  cdb_arbiter_if #(.N_REQ(N), .IDX_W(IW), .DATA_W(DW), .SRC_W(SW)) bus ();
  cdb_arbiter #(.N_REQ(N), .IDX_W(IW), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus.slave)
  );
  always #5 clk_in = ~clk_in;
  int checks = 0;
  int errors = 0;
  logic m_hv [N];
  logic [IW-1:0] m_idx [N];
  logic [DW-1:0] m_val [N];
  int m_ptr;
  logic m_cv;
  logic [IW-1:0] m_ci;
  logic [DW-1:0] m_cval;
  int m_cs;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 1'b0;
      m_idx[i] = '0;
      m_val[i] = '0;
    end
    m_ptr = 0;
    m_cv = 1'b0;
    m_ci = '0;
    m_cval = '0;
    m_cs = 0;
  endtask
  task automatic step(input logic rdy, input logic clr, input logic [N-1:0] v,
                      input logic [N*IW-1:0] ix, input logic [N*DW-1:0] vl);
    int g;
    logic [N-1:0] er;
    @(negedge clk_in);
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
    chk("cdb_rob_idx", 64'(bus.cdb_rob_idx), 64'(m_ci));
    chk("cdb_value", 64'(bus.cdb_value), 64'(m_cval));
    chk("cdb_src", 64'(bus.cdb_src), 64'(m_cs));
    bus.rdy_in = rdy;
    bus.clear = clr;
    bus.req_valid = v;
    bus.req_rob_idx = ix;
    bus.req_value = vl;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && m_hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) er[i] = rdy && !clr && (!m_hv[i] || g == i);
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    if (rdy) begin
      if (clr) begin
        for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
        m_cv = 1'b0;
      end else begin
        m_cv = (g >= 0);
        if (g >= 0) begin
          m_ci = m_idx[g];
          m_cval = m_val[g];
          m_cs = g;
          m_ptr = (g + 1) % N;
          m_hv[g] = 1'b0;
        end
        for (int i = 0; i < N; i++)
          if (v[i] && er[i]) begin
            m_hv[i] = 1'b1;
            m_idx[i] = ix[i*IW +: IW];
            m_val[i] = vl[i*DW +: DW];
          end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b1, 1'b0, '0, '0, '0);
  endtask
  initial begin
    logic [N-1:0] v;
    logic [N*IW-1:0] ix;
    logic [N*DW-1:0] vl;
    bus.rdy_in = 1'b1;
    bus.clear = 1'b0;
    bus.req_valid = '0;
    bus.req_rob_idx = '0;
    bus.req_value = '0;
    model_reset();
    #12 rst_in = 1'b0;
    idle(1);
    step(1'b1, 1'b0, 4'b0001, {(N*IW){1'b0}} | IW'(5), {(N*DW){1'b0}} | 32'hDEADBEEF);
    idle(3);
    step(1'b1, 1'b0, 4'b1111, {IW'(4), IW'(3), IW'(2), IW'(1)}, {32'h44, 32'h33, 32'h22, 32'h11});
    idle(5);
    step(1'b1, 1'b0, 4'b0010, {IW'(0), IW'(0), IW'(7), IW'(0)}, {4{32'h7}});
    step(1'b1, 1'b0, 4'b0010, {IW'(0), IW'(0), IW'(8), IW'(0)}, {4{32'h8}});
    step(1'b1, 1'b0, 4'b0010, {IW'(0), IW'(0), IW'(9), IW'(0)}, {4{32'h9}});
    idle(3);
    step(1'b1, 1'b0, 4'b0101, {IW'(0), IW'(3), IW'(0), IW'(1)}, {4{32'h5}});
    step(1'b1, 1'b1, 4'b1000, {IW'(6), IW'(0), IW'(0), IW'(0)}, {4{32'h6}});
    idle(3);
    step(1'b1, 1'b0, 4'b0011, {IW'(0), IW'(0), IW'(3), IW'(2)}, {32'h0, 32'h0, 32'hB, 32'hA});
    step(1'b1, 1'b0, '0, '0, '0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 4'b1111, '1, '1);
    idle(4);
    step(1'b1, 1'b0, 4'b0100, {IW'(0), IW'(9), IW'(0), IW'(0)}, {4{32'h99}});
    @(negedge clk_in);
    bus.rdy_in = 1'b1;
    bus.clear = 1'b0;
    bus.req_valid = '0;
    #2 rst_in = 1'b1;
    #1;
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'({N{1'b1}}));
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    idle(2);
    for (int ph = 0; ph < 4; ph++)
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < N; i++) begin
          ix[i*IW +: IW] = IW'($urandom);
          vl[i*DW +: DW] = $urandom;
        end
        v = (ph == 2) ? {N{1'b1}} : N'($urandom) & ((ph == 3) ? N'($urandom) : {N{1'b1}});
        step($urandom_range(0, 9) < ((ph == 1) ? 5 : 9), $urandom_range(0, 39) == 0, v, ix, vl);
      end
    idle(N + 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
